// File: rtl/proc_io_pkg.sv
// Shared definitions for the processor output collector.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: default widths, the buffered entry layout and a lowest-set-bit encoder.
package proc_io_pkg;

  localparam int NUBITS = 32;
  localparam int NCHAN  = 7;
  localparam int CHW    = 3;

  // Buffered entry: {last, chan, data}, data in the low bits.
  typedef struct packed {
    logic              last;
    logic [CHW-1:0]    chan;
    logic [NUBITS-1:0] data;
  } entry_t;

  // Index of the lowest set bit of v; 0 when v is all zeros.
  function automatic int lowest_set(input logic [31:0] v);
    lowest_set = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = i;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// Latency: a word written at edge N is readable after edge N; no write-to-read bypass.
// Backpressure: a write while full is accepted only together with a read; otherwise it is ignored.
//
// Ports: clk, rst (sync, active-high), push/wdata (write request), pop (read, ignored when empty),
//        rdata (head word), full, empty, level (occupancy 0..DEPTH).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [AW:0]      level_q, level_d;
  logic             wr, rd;

  assign full  = (level_q == (AW+1)'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;
  assign rdata = mem_q[rp_q];

  // A simultaneous read frees the slot, so a full FIFO can still take the write.
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    level_d = level_q;
    if (wr) wp_d = wp_q + 1'b1;
    if (rd) rp_d = rp_q + 1'b1;
    if (wr && !rd) level_d = level_q + 1'b1;
    if (rd && !wr) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      level_q <= level_d;
    end
  end

  // Storage is not reset; the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= wdata;
  end

endmodule

// File: rtl/proc_out_collector.sv
// Captures strobed processor output words, tags them with channel and frame position, buffers them.
// Latency: a word strobed in cycle N is presented on the head in cycle N+1 (no bypass).
// Backpressure: valid/ready on the head; a strobe into a full FIFO with no pop is dropped and flagged.
//
// Ports: clk, rst (sync, active-high); din/out_en (processor side);
//        m_data/m_chan/m_last/m_valid/m_ready (drain stream); level, ovf, err_multi (status).
module proc_out_collector #(
  parameter int NUBITS = proc_io_pkg::NUBITS,
  parameter int NCHAN  = proc_io_pkg::NCHAN,
  parameter int CHW    = proc_io_pkg::CHW,
  parameter int DEPTH  = 16,
  parameter int FRAME  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUBITS-1:0]      din,
  input  logic [NCHAN-1:0]       out_en,
  output logic [NUBITS-1:0]      m_data,
  output logic [CHW-1:0]         m_chan,
  output logic                   m_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  output logic                   err_multi
);

  import proc_io_pkg::*;

  localparam int FW = $clog2(FRAME);

  typedef struct packed {
    logic              last;
    logic [CHW-1:0]    chan;
    logic [NUBITS-1:0] data;
  } ent_t;

  logic           strobe;
  logic           multi;
  logic [CHW-1:0] chan;
  logic [FW-1:0]  cur_pos;
  logic [FW-1:0]  pos_q [NCHAN];
  logic [FW-1:0]  pos_d [NCHAN];
  logic           ovf_q, ovf_d;
  logic           err_q, err_d;
  ent_t           wr_ent, head;
  logic           full, empty, pop;

  assign strobe = |out_en;
  assign multi  = |(out_en & (out_en - NCHAN'(1)));
  assign chan   = CHW'(lowest_set(32'(out_en)));

  // Frame position of the captured channel, taken before its increment.
  always_comb begin
    cur_pos = '0;
    for (int k = 0; k < NCHAN; k++) begin
      if (chan == CHW'(k)) cur_pos = pos_q[k];
    end
  end

  // Counters advance on every capture, dropped or not, to stay frame-aligned with the processor.
  always_comb begin
    for (int k = 0; k < NCHAN; k++) begin
      pos_d[k] = pos_q[k];
      if (strobe && chan == CHW'(k)) begin
        pos_d[k] = (pos_q[k] == FW'(FRAME - 1)) ? '0 : pos_q[k] + 1'b1;
      end
    end
  end

  assign wr_ent.last = (cur_pos == FW'(FRAME - 1));
  assign wr_ent.chan = chan;
  assign wr_ent.data = din;

  assign m_valid = !empty;
  assign pop     = m_valid && m_ready;

  assign ovf_d = ovf_q | (strobe && full && !pop);
  assign err_d = err_q | (strobe && multi);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      for (int k = 0; k < NCHAN; k++) pos_q[k] <= '0;
    end else begin
      ovf_q <= ovf_d;
      err_q <= err_d;
      for (int k = 0; k < NCHAN; k++) pos_q[k] <= pos_d[k];
    end
  end

  sync_fifo #(
    .WIDTH ($bits(ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (strobe),
    .wdata (wr_ent),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // Storage is unreset, so the head fields are zeroed whenever nothing is valid.
  assign m_data    = m_valid ? head.data : '0;
  assign m_chan    = m_valid ? head.chan : '0;
  assign m_last    = m_valid ? head.last : 1'b0;
  assign ovf       = ovf_q;
  assign err_multi = err_q;

endmodule

// File: tb/tb_proc_out_collector.sv
// Directed bench for proc_out_collector: stimulus pushes expected entries into a queue,
// an independent monitor pops and compares on every accepted head word.
module tb_proc_out_collector;
  import proc_io_pkg::*;

  localparam int DEPTH = 16;
  localparam int FRAME = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUBITS-1:0] din;
  logic [NCHAN-1:0]  out_en;
  logic [NUBITS-1:0] m_data;
  logic [CHW-1:0]    m_chan;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;
  logic [4:0]        level;
  logic              ovf;
  logic              err_multi;

  int checks = 0;
  int errors = 0;

  entry_t sb[$];
  int     exp_lvl;
  bit     exp_ovf;
  bit     exp_multi;
  int     pos[NCHAN];

  always #5 clk = ~clk;

  proc_out_collector #(
    .NUBITS(NUBITS), .NCHAN(NCHAN), .CHW(CHW), .DEPTH(DEPTH), .FRAME(FRAME)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .out_en(out_en),
    .m_data(m_data), .m_chan(m_chan), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .level(level), .ovf(ovf), .err_multi(err_multi)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, applied just after the rising edge; the model advances to the
  // state expected after the next rising edge.
  task automatic cyc(input bit rst_v, input logic [NCHAN-1:0] en,
                     input logic [NUBITS-1:0] d, input bit rdy);
    bit     pop_m;
    bit     acc;
    int     ch;
    entry_t e;
    @(posedge clk);
    #1;
    rst = rst_v; out_en = en; din = d; m_ready = rdy;
    if (rst_v) begin
      sb.delete();
      exp_lvl = 0; exp_ovf = 0; exp_multi = 0;
      for (int k = 0; k < NCHAN; k++) pos[k] = 0;
    end else begin
      pop_m = rdy && (exp_lvl > 0);
      acc   = 0;
      if (en != 0) begin
        ch = 0;
        for (int k = NCHAN - 1; k >= 0; k--) if (en[k]) ch = k;
        if ((en & (en - 7'd1)) != 0) exp_multi = 1;
        e.last = (pos[ch] == FRAME - 1);
        e.chan = CHW'(ch);
        e.data = d;
        pos[ch] = (pos[ch] + 1) % FRAME;
        acc = (exp_lvl < DEPTH) || pop_m;
        if (acc) sb.push_back(e);
        else exp_ovf = 1;
      end
      exp_lvl = exp_lvl + (acc ? 1 : 0) - (pop_m ? 1 : 0);
    end
  endtask

  // Idle cycle with the consumer stalled, then compare status against the model.
  task automatic settle_check(input string tag);
    cyc(0, '0, '0, 0);
    @(negedge clk);
    chk({tag, "_level"},   32'(level),     32'(exp_lvl));
    chk({tag, "_valid"},   32'(m_valid),   32'(exp_lvl > 0));
    chk({tag, "_ovf"},     32'(ovf),       32'(exp_ovf));
    chk({tag, "_multi"},   32'(err_multi), 32'(exp_multi));
  endtask

  // Monitor: compares every accepted head word against the scoreboard.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got data %0h chan %0d, expected none", m_data, m_chan);
        end else begin
          e = sb.pop_front();
          chk("head_data", m_data, e.data);
          chk("head_chan", 32'(m_chan), 32'(e.chan));
          chk("head_last", 32'(m_last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; out_en = '0; din = '0; m_ready = 1'b0;
    exp_lvl = 0; exp_ovf = 0; exp_multi = 0;
    for (int k = 0; k < NCHAN; k++) pos[k] = 0;

    // Reset state
    cyc(1, '0, '0, 0);
    cyc(1, '0, '0, 0);
    settle_check("reset");
    chk("reset_data", m_data, 32'h0);
    chk("reset_chan", 32'(m_chan), 32'h0);
    chk("reset_last", 32'(m_last), 32'h0);

    // Single capture on channel 1
    cyc(0, 7'b0000010, 32'h3F800000, 0);
    settle_check("single");
    chk("single_data", m_data, 32'h3F800000);
    chk("single_chan", 32'(m_chan), 32'd1);
    chk("single_last", 32'(m_last), 32'd0);
    chk("single_lvl1", 32'(level), 32'd1);
    cyc(0, '0, '0, 1);

    // Frame of 8 on channel 1 plus a wrap word, consumer always ready
    cyc(1, '0, '0, 0);
    for (int i = 1; i <= 9; i++) cyc(0, 7'b0000010, 32'(i), 1);
    cyc(0, '0, '0, 1);
    settle_check("frame");
    chk("frame_sb_empty", 32'(sb.size()), 32'd0);

    // Overflow: 17 strobes on channel 2 into a stalled consumer
    cyc(1, '0, '0, 0);
    for (int i = 1; i <= 17; i++) cyc(0, 7'b0000100, 32'(i), 0);
    settle_check("ovf");
    chk("ovf_level16", 32'(level), 32'd16);
    chk("ovf_flag",    32'(ovf),   32'd1);
    for (int i = 0; i < 17; i++) cyc(0, '0, '0, 1);
    settle_check("drain");
    chk("drain_valid0", 32'(m_valid), 32'd0);
    chk("drain_ovf_sticky", 32'(ovf), 32'd1);

    // Full FIFO with simultaneous push and pop
    cyc(1, '0, '0, 0);
    for (int i = 1; i <= 16; i++) cyc(0, 7'b0001000, 32'h100 + 32'(i), 0);
    cyc(0, 7'b0001000, 32'hABC, 1);
    settle_check("pushpop");
    chk("pushpop_level16", 32'(level), 32'd16);
    chk("pushpop_no_ovf",  32'(ovf),   32'd0);
    for (int i = 0; i < 16; i++) cyc(0, '0, '0, 1);
    settle_check("pushpop_drain");

    // Multiple strobes, then reset with a strobe in flight
    cyc(1, '0, '0, 0);
    cyc(0, 7'b0100100, 32'h55, 0);
    settle_check("multi");
    chk("multi_flag", 32'(err_multi), 32'd1);
    chk("multi_chan", 32'(m_chan), 32'd2);
    cyc(0, 7'b0000100, 32'h56, 0);
    cyc(0, 7'b0000100, 32'h57, 0);
    cyc(1, 7'b0000100, 32'hDEAD, 0);
    settle_check("midrst");
    chk("midrst_data",  m_data, 32'h0);
    chk("midrst_chan",  32'(m_chan), 32'h0);
    chk("midrst_last",  32'(m_last), 32'h0);
    chk("midrst_multi", 32'(err_multi), 32'd0);
    // Channel-2 frame restarts: the 8th word after reset carries last
    for (int i = 1; i <= 8; i++) cyc(0, 7'b0000100, 32'h200 + 32'(i), 1);
    cyc(0, '0, '0, 1);
    settle_check("restart");
    chk("restart_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_out_collector.md
# proc_out_collector

Downstream capture stage for a generated processor's output port. Each cycle it samples the 32-bit `out` word whenever one of the decoded `out_en` strobes is high, tags it with the channel index and a per-channel frame position, and buffers it in a FIFO. Downstream logic drains the buffered words through a valid/ready stream. This decouples the processor's single-cycle output strobes from slower consumers such as UART, DMA or capture RAM, and flags any lost words.

## Interface
Parameters:
- `NUBITS`, 32, data word width (matches processor `NUBITS`)
- `NCHAN`, 7, width of the decoded `out_en` bus
- `CHW`, 3, channel index width, `$clog2(NCHAN)`
- `DEPTH`, 16, FIFO depth; power of two, minimum 2
- `FRAME`, 8, words per frame per channel (matches `FFTSIZ`)

Ports:
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  reset; synchronous, active-high
- `din`  in  NUBITS  processor `out` word (signed, passed through unaltered)
- `out_en`  in  NCHAN  decoded output strobes; bit k = output address k
- `m_data`  out  NUBITS  head word
- `m_chan`  out  CHW  channel index of head word
- `m_last`  out  1  head word is position FRAME-1 of its channel frame
- `m_valid`  out  1  head word valid
- `m_ready`  in  1  consumer accepts head word
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `ovf`  out  1  sticky: a word was dropped because the FIFO was full
- `err_multi`  out  1  sticky: `out_en` had more than one bit set

## Operation
- Capture: when `out_en != 0`, a push occurs with channel = index of the lowest set bit. If more than one bit is set, only that lowest channel is captured and `err_multi` is set.
- Frame position: one counter per channel, `$clog2(FRAME)` bits, reset to 0. It increments on every capture for that channel and wraps FRAME-1 to 0. The stored `last` bit equals (counter == FRAME-1) before the increment.
- The counter advances even when the word is dropped, so frame alignment stays locked to the processor.
- FIFO entry = {`last`, chan, `din`}. Pop occurs when `m_valid && m_ready`.
- Full (`level == DEPTH`):
  - push with no pop: word discarded, `ovf` set.
  - push with simultaneous pop: push accepted, `level` unchanged.
- Empty with simultaneous push: no bypass; the word appears the next cycle.
- `ovf` and `err_multi` clear only on `rst`.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally. `level` is tracked separately: +1 on push only, -1 on pop only, unchanged on both or neither.

## Timing
- Reset (synchronous, `rst` high at an edge) clears:
  - `m_valid`=0, `m_data`=0, `m_chan`=0, `m_last`=0, `level`=0, `ovf`=0, `err_multi`=0
  - all pointers and frame counters = 0
- Reset mid-operation discards all buffered words. A strobe in the same cycle as `rst` is ignored.
- Latency: a word strobed in cycle N is presented in cycle N+1 (`m_valid`=1 after edge N) when the FIFO was empty.
- Head outputs (`m_data`, `m_chan`, `m_last`) are first-word-fall-through and stay stable while `m_valid && !m_ready`.
- Throughput: one push and one pop per cycle, sustained.
- `m_ready` may be high while `m_valid` is low; no effect.
- Flags assert in the cycle after the offending edge.

## Structure
- Package `proc_io_pkg`: `NUBITS`, `NCHAN`, `CHW` defaults; the entry typedef {last, chan, data}; a lowest-set-bit encode function.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH): registered storage with combinational read at the head pointer, plus full/empty/level outputs.
- Top level holds the channel encoder, the per-channel frame counters, and the sticky flags.

## Test plan
- Reset, then `out_en`=7'b0000010, `din`=32'h3F800000 for one cycle -> next cycle `m_valid`=1, `m_chan`=1, `m_data`=32'h3F800000, `m_last`=0, `level`=1.
- 8 strobes on channel 1 (`din` = 1..8), `m_ready`=1 -> eight words in order; only word 8 has `m_last`=1; a ninth strobe has `m_last`=0 (wrap).
- `m_ready`=0, 17 strobes on channel 2 -> `level`=16, `ovf`=1. Draining yields words 1..16, then `m_valid`=0.
- FIFO full, push and pop in the same cycle -> `level` stays 16, `ovf` stays 0, new word emerges last.
- `out_en`=7'b0100100 -> channel 2 captured, `err_multi`=1. Then `rst` mid-stream -> all outputs 0 next cycle; the channel-2 frame counter restarts at 0.
